// File: rtl/smi_write_align_arbiter_if.sv
// Bus bundle between the write requesters, the arbiter and the shared SMI
// byte-data aligner. The slave view belongs to the arbiter; the master view is
// the environment (requesters plus aligner).
interface smi_write_align_arbiter_if #(
  parameter int FlitWidth     = 16,
  parameter int NumPorts      = 4,
  parameter int PortIndexSize = 2
);
  // Requester side
  logic [NumPorts-1:0]             reqSetupReady;
  logic [8*NumPorts-1:0]           reqByteOffset;
  logic [NumPorts-1:0]             reqSetupStop;
  logic [NumPorts-1:0]             reqInReady;
  logic [8*NumPorts-1:0]           reqInEofc;
  logic [FlitWidth*8*NumPorts-1:0] reqInData;
  logic [NumPorts-1:0]             reqInStop;
  // Aligner side
  logic                            setupReady;
  logic [7:0]                      byteOffset;
  logic                            setupStop;
  logic                            smiOutReady;
  logic [7:0]                      smiOutEofc;
  logic [FlitWidth*8-1:0]          smiOutData;
  logic                            smiOutStop;
  // Burst tagging for downstream AXI logic
  logic                            grantValid;
  logic [PortIndexSize-1:0]        grantId;

  modport slave (
    input  reqSetupReady, reqByteOffset, reqInReady, reqInEofc, reqInData,
           setupStop, smiOutStop,
    output reqSetupStop, reqInStop, setupReady, byteOffset, smiOutReady,
           smiOutEofc, smiOutData, grantValid, grantId
  );

  modport master (
    output reqSetupReady, reqByteOffset, reqInReady, reqInEofc, reqInData,
           setupStop, smiOutStop,
    input  reqSetupStop, reqInStop, setupReady, byteOffset, smiOutReady,
           smiOutEofc, smiOutData, grantValid, grantId
  );
endinterface

// File: rtl/smi_write_align_arbiter.sv
// Round-robin arbiter sharing one SMI byte-data aligner between NumPorts write
// requesters. A grant covers one setup transfer plus one complete flit frame;
// the data path is a combinational mux whose select (grant_q) is registered.
module smi_write_align_arbiter #(
  parameter int FlitWidth     = 16,
  parameter int NumPorts      = 4,
  parameter int PortIndexSize = 2
) (
  input logic                     clk,
  input logic                     srst,
  smi_write_align_arbiter_if.slave bus
);

  localparam int DataBits = FlitWidth * 8;

  typedef enum logic [1:0] {IDLE, SETUP, FRAME} state_t;

  state_t                   state_q, state_d;
  logic [PortIndexSize-1:0] grant_q, grant_d;
  logic [PortIndexSize-1:0] prio_q, prio_d;

  logic                     found;
  logic [PortIndexSize-1:0] winner;
  logic [PortIndexSize-1:0] cand;
  int unsigned              idx;

  logic                     sel_setup_ready;
  logic [7:0]               sel_offset;
  logic                     sel_in_ready;
  logic [7:0]               sel_eofc;
  logic [DataBits-1:0]      sel_data;

  // State register: FSM state, current grant and round-robin start point.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (!srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Round-robin scan: first requesting port at or after prio_q, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx  = ({{(32-PortIndexSize){1'b0}}, prio_q} + i) % NumPorts;
      cand = PortIndexSize'(idx);
      if (!found && bus.reqSetupReady[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Port mux driven by the registered grant.
  always_comb begin
    sel_setup_ready = 1'b0;
    sel_offset      = '0;
    sel_in_ready    = 1'b0;
    sel_eofc        = '0;
    sel_data        = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (grant_q == PortIndexSize'(p)) begin
        sel_setup_ready = bus.reqSetupReady[p];
        sel_offset      = bus.reqByteOffset[8*p +: 8];
        sel_in_ready    = bus.reqInReady[p];
        sel_eofc        = bus.reqInEofc[8*p +: 8];
        sel_data        = bus.reqInData[DataBits*p +: DataBits];
      end
    end
  end

  // Next state and handshake outputs; reset forces the idle output set so
  // nothing transfers during the reset cycle.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    prio_d           = prio_q;
    bus.reqSetupStop = bus.reqSetupReady;
    bus.reqInStop    = bus.reqInReady;
    bus.setupReady   = 1'b0;
    bus.smiOutReady  = 1'b0;
    bus.grantValid   = 1'b0;
    bus.byteOffset   = sel_offset;
    bus.smiOutEofc   = sel_eofc;
    bus.smiOutData   = sel_data;
    if (srst) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_d = winner;
            state_d = SETUP;
          end
        end
        SETUP: begin
          bus.setupReady            = sel_setup_ready;
          bus.reqSetupStop[grant_q] = bus.setupStop & sel_setup_ready;
          if (sel_setup_ready && !bus.setupStop) begin
            bus.grantValid = 1'b1;
            state_d        = FRAME;
          end
        end
        FRAME: begin
          bus.smiOutReady        = sel_in_ready;
          bus.reqInStop[grant_q] = bus.smiOutStop & sel_in_ready;
          if (sel_in_ready && !bus.smiOutStop && (|sel_eofc)) begin
            state_d = IDLE;
            prio_d  = (grant_q == PortIndexSize'(NumPorts - 1)) ? '0
                                                                : grant_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.grantId = grant_q;

endmodule

// File: tb/tb_smi_write_align_arbiter.sv
// Randomized bench for smi_write_align_arbiter: per-port requester drivers and
// a random-stop aligner sink, checked cycle by cycle against a transaction-level
// reference model, followed by a directed mid-frame reset sequence.
module tb_smi_write_align_arbiter;

  localparam int FW  = 16;
  localparam int NP  = 4;
  localparam int PIS = 2;
  localparam int W   = FW * 8;
  localparam int NTX = 6;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  smi_write_align_arbiter_if #(.FlitWidth(FW), .NumPorts(NP), .PortIndexSize(PIS)) bus ();

  smi_write_align_arbiter #(.FlitWidth(FW), .NumPorts(NP), .PortIndexSize(PIS)) dut (
    .clk (clk),
    .srst(srst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Generated traffic, shared read-only by drivers and model (separate cursors).
  logic [7:0]   off_arr [NP][NTX];
  int           tx_len  [NP][NTX];
  logic [7:0]   q_eofc  [NP][$];
  logic [W-1:0] q_data  [NP][$];

  int done_cnt = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit sink_en  = 1'b0;

  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int p, input int fi);
    bus.reqInReady[p]        = 1'b1;
    bus.reqInEofc[8*p +: 8]  = q_eofc[p][fi];
    bus.reqInData[W*p +: W]  = q_data[p][fi];
  endtask

  // One requester: setup, then its frame, honouring the hold-until-transfer rule.
  task automatic drive_port(input int p);
    int fi;
    bit early;
    fi = 0;
    for (int t = 0; t < NTX; t++) begin
      if (t != 0) repeat ($urandom_range(0, 5)) step();
      early = (p == 2 && t == 0) || ($urandom_range(0, 3) == 0);
      bus.reqSetupReady[p]        = 1'b1;
      bus.reqByteOffset[8*p +: 8] = off_arr[p][t];
      if (early) present(p, fi);
      do @(negedge clk); while (!(bus.reqSetupReady[p] && !bus.reqSetupStop[p]));
      step();
      bus.reqSetupReady[p] = 1'b0;
      for (int f = 0; f < tx_len[p][t]; f++) begin
        if (!(early && f == 0)) begin
          repeat ($urandom_range(0, 2)) step();
          present(p, fi);
        end
        do @(negedge clk); while (!(bus.reqInReady[p] && !bus.reqInStop[p]));
        step();
        bus.reqInReady[p] = 1'b0;
        fi++;
      end
    end
    done_cnt++;
  endtask

  // Aligner sink: random stops with occasional 5-cycle stop bursts.
  initial begin
    int burst;
    burst = 0;
    forever begin
      step();
      if (sink_en) begin
        bus.setupStop = ($urandom_range(0, 2) == 0);
        if (burst > 0) begin
          bus.smiOutStop = 1'b1;
          burst--;
        end else if ($urandom_range(0, 9) == 0) begin
          bus.smiOutStop = 1'b1;
          burst = 4;
        end else begin
          bus.smiOutStop = ($urandom_range(0, 3) == 0);
        end
      end else begin
        bus.setupStop  = 1'b0;
        bus.smiOutStop = 1'b0;
      end
    end
  end

  // Reference model: one owner at a time, round-robin from the port after the
  // last finished frame, exact per-port ordering of offsets and flits.
  typedef enum {M_IDLE, M_SETUP, M_FRAME} mstate_t;
  mstate_t m_state = M_IDLE;
  int m_port = 0;
  int m_prio = 0;
  int mti [NP];
  int mfi [NP];

  always @(negedge clk) begin
    if (mon_en) begin
      logic [NP-1:0] sr, ir, es;
      bit hit;
      sr = bus.reqSetupReady;
      ir = bus.reqInReady;
      case (m_state)
        M_IDLE: begin
          check("idle_setupReady", bus.setupReady, 0);
          check("idle_smiOutReady", bus.smiOutReady, 0);
          check("idle_grantValid", bus.grantValid, 0);
          check("idle_setup_stops", bus.reqSetupStop, sr);
          check("idle_in_stops", bus.reqInStop, ir);
          hit = 1'b0;
          for (int k = 0; k < NP; k++) begin
            int c;
            c = (m_prio + k) % NP;
            if (!hit && sr[c]) begin
              hit     = 1'b1;
              m_port  = c;
              m_state = M_SETUP;
            end
          end
        end
        M_SETUP: begin
          check("setup_grantId", bus.grantId, m_port);
          check("setup_setupReady", bus.setupReady, 1);
          check("setup_byteOffset", bus.byteOffset, off_arr[m_port][mti[m_port]]);
          check("setup_smiOutReady", bus.smiOutReady, 0);
          check("setup_grantValid", bus.grantValid, !bus.setupStop);
          es = sr;
          es[m_port] = bus.setupStop;
          check("setup_setup_stops", bus.reqSetupStop, es);
          check("setup_in_stops", bus.reqInStop, ir);
          if (!bus.setupStop) begin
            mti[m_port]++;
            m_state = M_FRAME;
          end
        end
        default: begin
          check("frame_grantId", bus.grantId, m_port);
          check("frame_setupReady", bus.setupReady, 0);
          check("frame_grantValid", bus.grantValid, 0);
          check("frame_smiOutReady", bus.smiOutReady, ir[m_port]);
          check("frame_setup_stops", bus.reqSetupStop, sr);
          es = ir;
          es[m_port] = bus.smiOutStop & ir[m_port];
          check("frame_in_stops", bus.reqInStop, es);
          if (ir[m_port]) begin
            check("frame_eofc", bus.smiOutEofc, q_eofc[m_port][mfi[m_port]]);
            check("frame_data", bus.smiOutData, q_data[m_port][mfi[m_port]]);
            if (!bus.smiOutStop) begin
              if (q_eofc[m_port][mfi[m_port]] != 8'd0) begin
                m_state = M_IDLE;
                m_prio  = (m_port + 1) % NP;
              end
              mfi[m_port]++;
            end
          end
        end
      endcase
    end
  end

  initial begin
    srst              = 1'b0;
    bus.reqSetupReady = '0;
    bus.reqByteOffset = '0;
    bus.reqInReady    = '0;
    bus.reqInEofc     = '0;
    bus.reqInData     = '0;
    bus.setupStop     = 1'b0;
    bus.smiOutStop    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      mti[p] = 0;
      mfi[p] = 0;
      for (int t = 0; t < NTX; t++) begin
        int r;
        off_arr[p][t] = 8'($urandom_range(0, FW - 1));
        tx_len[p][t]  = $urandom_range(1, 4);
        for (int f = 0; f < tx_len[p][t]; f++) begin
          q_data[p].push_back({$urandom, $urandom, $urandom, $urandom});
          if (f != tx_len[p][t] - 1) begin
            q_eofc[p].push_back(8'd0);
          end else begin
            r = $urandom_range(0, 3);
            q_eofc[p].push_back(r == 0 ? 8'(FW) : r == 1 ? 8'(FW + 4) :
                                r == 2 ? 8'hff : 8'($urandom_range(1, FW)));
          end
        end
      end
    end
    repeat (3) step();

    // All ports request together while reset is still held.
    for (int p = 0; p < NP; p++) begin
      automatic int pp = p;
      fork
        drive_port(pp);
      join_none
    end
    @(negedge clk);
    check("rst_setupReady", bus.setupReady, 0);
    check("rst_smiOutReady", bus.smiOutReady, 0);
    check("rst_grantValid", bus.grantValid, 0);
    check("rst_grantId", bus.grantId, 0);
    check("rst_setup_stops", bus.reqSetupStop, 4'hf);
    check("rst_in_stops", bus.reqInStop, bus.reqInReady);
    step();
    srst    = 1'b1;
    mon_en  = 1'b1;
    sink_en = 1'b1;

    while (done_cnt < NP && cyc < 20000) step();
    check("all_ports_done", done_cnt, NP);
    step();
    mon_en  = 1'b0;
    sink_en = 1'b0;
    repeat (3) step();

    // Directed: reset mid-frame of port 1 while port 3 waits.
    bus.reqSetupReady[1] = 1'b1;
    bus.reqByteOffset[15:8] = 8'h09;
    @(negedge clk);
    check("dir_arb_cycle_setupReady", bus.setupReady, 0);
    step();
    bus.reqSetupReady[3] = 1'b1;
    bus.reqByteOffset[31:24] = 8'h2a;
    @(negedge clk);
    check("dir_p1_grantValid", bus.grantValid, 1);
    check("dir_p1_grantId", bus.grantId, 1);
    check("dir_p1_byteOffset", bus.byteOffset, 8'h09);
    step();
    bus.reqSetupReady[1] = 1'b0;
    bus.reqInReady[1]    = 1'b1;
    bus.reqInEofc[15:8]  = 8'd0;
    bus.reqInData[W +: W] = {4{32'hdeadbeef}};
    @(negedge clk);
    check("dir_p1_flit_fwd", bus.smiOutReady, 1);
    check("dir_p3_held", bus.reqSetupStop[3], 1);
    step();
    srst = 1'b0;
    @(negedge clk);
    check("dir_rst_setupReady", bus.setupReady, 0);
    check("dir_rst_smiOutReady", bus.smiOutReady, 0);
    check("dir_rst_grantValid", bus.grantValid, 0);
    check("dir_rst_p1_in_stop", bus.reqInStop[1], 1);
    check("dir_rst_p3_setup_stop", bus.reqSetupStop[3], 1);
    step();
    srst = 1'b1;
    bus.reqInReady[1] = 1'b0;
    @(negedge clk);
    check("dir_after_rst_grantId", bus.grantId, 0);
    check("dir_after_rst_setupReady", bus.setupReady, 0);
    step();
    @(negedge clk);
    check("dir_p3_setupReady", bus.setupReady, 1);
    check("dir_p3_grantId", bus.grantId, 3);
    check("dir_p3_byteOffset", bus.byteOffset, 8'h2a);
    check("dir_p3_grantValid", bus.grantValid, 1);
    step();
    bus.reqSetupReady[3] = 1'b0;
    bus.reqInReady[3]    = 1'b1;
    bus.reqInEofc[31:24] = 8'(FW + 4);
    bus.reqInData[3*W +: W] = {4{32'h0badf00d}};
    @(negedge clk);
    check("dir_p3_smiOutReady", bus.smiOutReady, 1);
    check("dir_p3_eofc", bus.smiOutEofc, FW + 4);
    check("dir_p3_data", bus.smiOutData, {4{32'h0badf00d}});
    step();
    bus.reqInReady[3]    = 1'b0;
    bus.reqSetupReady[0] = 1'b1;
    bus.reqSetupReady[3] = 1'b1;
    @(negedge clk);
    check("dir_gap_setupReady", bus.setupReady, 0);
    step();
    @(negedge clk);
    check("dir_wrap_setupReady", bus.setupReady, 1);
    check("dir_wrap_grantId", bus.grantId, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
